dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the beat-count field cmd_len.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1: command offered.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when both cmd_valid and cmd_ready are high at a clk edge.
REQ-006 SHALL have port cmd_op, input, 2: operation code; 00 MULT, 01 MACC, 10 WIDE, 11 CLEAR.
REQ-007 SHALL have port cmd_len, input, LEN_W: MACC beat count.
REQ-008 SHALL have port opnd_valid, input, 1: operand pair (A/B/C) present at the DSP inputs.
REQ-009 SHALL have port opnd_ready, output, 1: beat consumed when both opnd_valid and opnd_ready are high.
REQ-010 SHALL have port opmode, output, 7: DSP opmode; [1:0] X select, [3:2] Y select, [6:4] Z select.
REQ-011 SHALL have port alumode, output, 4: DSP alumode; constant 4'b0000 (add).
REQ-012 SHALL have port ce_p, output, 1: P register clock enable.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse; P holds the final result during this cycle.

Function
REQ-015 The DSP SHALL run with unregistered A/B/M/opmode and a registered P, so the P update lands on the clk edge that ends the issue cycle.
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, CLR, DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; on command accept, op and len SHALL be latched, and the beat counter cleared.
REQ-018 IDLE SHALL go to CLR on accept of op 11, to ISSUE on accept of any other op, and otherwise stay in IDLE.
REQ-019 Required beats: MULT=1, WIDE=2, MACC=cmd_len; a MACC with cmd_len=0 SHALL be treated as 1.
REQ-020 In ISSUE, opnd_ready SHALL be 1, and ce_p SHALL equal opnd_valid, combinationally.
REQ-021 The beat counter SHALL increment only on an accepted beat.
REQ-022 Opmode in ISSUE SHALL be: beat 0 of any op = 7'h05 (X=M, Y=M, Z=0).
REQ-023 Opmode in ISSUE SHALL be: MACC beat>=1 = 7'h25 (Z=P).
REQ-024 Opmode in ISSUE SHALL be: WIDE beat 1 = 7'h65 (Z=P>>>17).
REQ-025 On a stall (opnd_valid=0 in ISSUE), opmode SHALL hold the current beat's value, ce_p SHALL be 0, and the counter and P SHALL be unchanged.
REQ-026 ISSUE SHALL go to DONE on the edge that accepts the last beat.
REQ-027 CLR SHALL last one cycle with opmode=7'h00, ce_p=1 and opnd_ready=0, then go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, ce_p=0 and opnd_ready=0, then go to IDLE; a new command is accepted no earlier than the cycle after DONE.
REQ-029 Outside ISSUE and CLR, opmode SHALL be 7'h00, ce_p SHALL be 0, and opnd_ready SHALL be 0.
REQ-030 cmd_valid seen in any non-IDLE state SHALL be ignored (no accept, no side effect).
REQ-031 The counter SHALL be LEN_W bits wide and SHALL never wrap, because the ISSUE exit happens at count = len-1.

Reset
REQ-032 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE, and the counter, latched op and latched len SHALL be 0.
REQ-033 While rst_n=0, cmd_ready, opnd_ready, ce_p, busy and done SHALL be 0, and opmode SHALL be 7'h00.
REQ-034 A reset during ISSUE or CLR SHALL abandon the operation with no done pulse; P contents are then undefined to the user.

Structure
REQ-035 Package dsp_ctrl_pkg SHALL hold the op encodings, the FSM state enum, and the opmode constants OPM_ZERO=7'h00, OPM_MULT=7'h05, OPM_MACC=7'h25, OPM_WIDE=7'h65.
REQ-036 The opmode/ce_p decode from (state, op, beat counter, opnd_valid) SHALL be sub-module dsp_opmode_decode, purely combinational; the FSM and counter stay in dsp_mac_sequencer.

Verification
REQ-037 MULT with opnd_valid=1: cmd accept -> next cycle opmode=05, ce_p=1, opnd_ready=1 -> following cycle done=1, busy=1 -> then idle with cmd_ready=1.
REQ-038 MACC with len=4 and opnd_valid low for one cycle after beat 1: accepted beats show opmode 05, 25, 25, 25; the bubble cycle shows ce_p=0 and opmode=25; done comes exactly one cycle after the 4th accepted beat.
REQ-039 WIDE: two accepted beats show opmode 05 then 65; done follows the second beat; a DSP model's P equals (A1*B1) + ((A0*B0) >>> 17).
REQ-040 CLEAR: a single cycle with opmode=00, ce_p=1, opnd_ready=0; then done; model P=0.
REQ-041 rst_n=0 for one cycle after 2 of 4 MACC beats: next cycle state IDLE, busy=0, cmd_ready=1, no done; a following MULT completes normally.
REQ-042 MACC with len=0 -> exactly one beat with opmode 05, then done; cmd_valid held high during busy -> no second accept until after DONE.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared encodings for the DSP MAC sequencer: op codes, FSM states and
// the DSP opmode/alumode constants driven toward the DSP slice.
package dsp_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MACC  = 2'b01,
    OP_WIDE  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CLR,
    DONE
  } state_e;

  // opmode = {Z[2:0], Y[1:0], X[1:0]}
  localparam logic [6:0] OPM_ZERO = 7'h00; // X=0, Y=0, Z=0
  localparam logic [6:0] OPM_MULT = 7'h05; // X=M, Y=M, Z=0
  localparam logic [6:0] OPM_MACC = 7'h25; // X=M, Y=M, Z=P
  localparam logic [6:0] OPM_WIDE = 7'h65; // X=M, Y=M, Z=P>>>17

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Opmode for an issue beat: the first beat of every op starts from zero,
  // later beats fold in the previous P (plain or shifted for WIDE).
  function automatic logic [6:0] issue_opmode(input op_e op, input logic first_beat);
    logic [6:0] opm;
    opm = OPM_MULT;
    if (!first_beat) begin
      case (op)
        OP_MACC: opm = OPM_MACC;
        OP_WIDE: opm = OPM_WIDE;
        default: opm = OPM_MULT;
      endcase
    end
    return opm;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Command/operand handshake bundle between a command source and the
// DSP MAC sequencer.
interface dsp_mac_sequencer_if #(
  parameter int LEN_W = 8
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             opnd_valid;
  logic             opnd_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_len, opnd_valid,
    input  cmd_ready, opnd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, opnd_valid,
    output cmd_ready, opnd_ready
  );

endinterface

// File: rtl/dsp_opmode_decode.sv
// Combinational decode of DSP opmode and P clock enable from the
// sequencer state, latched op, beat counter and operand valid.
module dsp_opmode_decode
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  state_e           state,
  input  op_e              op,
  input  logic [LEN_W-1:0] cnt,
  input  logic             opnd_valid,
  output logic [6:0]       opmode,
  output logic             ce_p
);

  // Opmode holds the current beat's value during a stall; only ce_p drops.
  always_comb begin
    opmode = OPM_ZERO;
    ce_p   = 1'b0;
    case (state)
      ISSUE: begin
        opmode = issue_opmode(op, cnt == '0);
        ce_p   = opnd_valid;
      end
      CLR: begin
        opmode = OPM_ZERO;
        ce_p   = 1'b1;
      end
      default: begin
        opmode = OPM_ZERO;
        ce_p   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequencer driving a DSP slice (unregistered A/B/M/opmode, registered P)
// through MULT, MACC, WIDE and CLEAR operations.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             opnd_valid,
  output logic             opnd_ready,
  output logic [6:0]       opmode,
  output logic [3:0]       alumode,
  output logic             ce_p,
  output logic             busy,
  output logic             done
);

  state_e           state;
  op_e              op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] last_cnt;
  logic [6:0]       dec_opmode;
  logic             dec_ce_p;

  // Index of the final beat; a zero-length MACC still issues one beat.
  always_comb begin
    last_cnt = '0;
    case (op_q)
      OP_MACC: last_cnt = (len_q == '0) ? '0 : len_q - LEN_W'(1);
      OP_WIDE: last_cnt = LEN_W'(1);
      default: last_cnt = '0;
    endcase
  end

  // Control FSM with command latch and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_MULT;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_e'(cmd_op);
            len_q <= cmd_len;
            cnt   <= '0;
            state <= (op_e'(cmd_op) == OP_CLEAR) ? CLR : ISSUE;
          end
        end
        ISSUE: begin
          if (opnd_valid) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == last_cnt) state <= DONE;
          end
        end
        CLR:     state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dsp_opmode_decode #(
    .LEN_W(LEN_W)
  ) u_decode (
    .state      (state),
    .op         (op_q),
    .cnt        (cnt),
    .opnd_valid (opnd_valid),
    .opmode     (dec_opmode),
    .ce_p       (dec_ce_p)
  );

  // State-derived outputs are forced quiet while reset is asserted, not
  // only after the reset edge has been taken.
  assign cmd_ready  = rst_n && (state == IDLE);
  assign opnd_ready = rst_n && (state == ISSUE);
  assign busy       = rst_n && (state != IDLE);
  assign done       = rst_n && (state == DONE);
  assign ce_p       = rst_n && dec_ce_p;
  assign opmode     = rst_n ? dec_opmode : OPM_ZERO;
  assign alumode    = ALU_ADD;

endmodule
